// File: rtl/fsm_multi_cond_ctrl.sv
// Condition-gathering controller: a tracker collects N_COND conditions into a
// "seen" mask (any order or strict index order) while a controller, armed by
// start, walks IDLE -> ARMED -> COMPLETE -> DONE with an ARMED timeout to FAULT.
module fsm_multi_cond_ctrl #(
  parameter int unsigned N_COND  = 4,
  parameter int unsigned ORDERED = 0,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TMR_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_COND-1:0] cond,
  input  logic              start,
  input  logic              clear,
  output logic [N_COND-1:0] seen,
  output logic [1:0]        stage,
  output logic              busy,
  output logic              done,
  output logic              fault
);

  // ptr must reach N_COND once every condition has been taken in order
  localparam int unsigned PTR_W = $clog2(N_COND) + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_COMPLETE = 3'd2,
    S_DONE     = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [N_COND-1:0] seen_q, seen_d;
  logic [N_COND-1:0] new_bits, exp_bit;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              all_seen, tracking, order_err;

  assign all_seen = &seen_q;
  assign tracking = (state_q == S_IDLE) || (state_q == S_ARMED);
  assign new_bits = cond & ~seen_q;
  assign exp_bit  = N_COND'(1) << ptr_q;

  // Tracker next state: accumulate conditions and flag out-of-order arrivals
  always_comb begin
    seen_d    = seen_q;
    ptr_d     = ptr_q;
    order_err = 1'b0;
    if (tracking) begin
      if (ORDERED == 0) begin
        seen_d = seen_q | cond;
      end else if (new_bits != '0) begin
        if (new_bits == exp_bit) begin
          seen_d = seen_q | new_bits;
          ptr_d  = ptr_q + PTR_W'(1);
        end else begin
          order_err = 1'b1;
        end
      end
    end
  end

  // Controller next state and ARMED dwell timer
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    case (state_q)
      S_IDLE: begin
        if (order_err)                    state_d = S_FAULT;
        else if (start && all_seen)       state_d = S_COMPLETE;
        else if (start && seen_q != '0)   state_d = S_ARMED;
      end
      S_ARMED: begin
        if (order_err)                              state_d = S_FAULT;
        else if (all_seen)                          state_d = S_COMPLETE;
        else if (timer_q == TMR_W'(TIMEOUT - 1))    state_d = S_FAULT;
        else                                        timer_d = timer_q + TMR_W'(1);
      end
      S_COMPLETE: state_d = S_DONE;
      S_DONE:     state_d = S_DONE;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_IDLE;
    endcase
  end

  // State registers; reset and clear both return everything to IDLE
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= S_IDLE;
      seen_q  <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= (state_d == S_FAULT && order_err) ? seen_q : seen_d;
      ptr_q   <= order_err ? ptr_q : ptr_d;
      timer_q <= timer_d;
    end
  end

  // Output decode from registered state
  always_comb begin
    stage = 2'b00;
    case (state_q)
      S_ARMED:    stage = 2'b01;
      S_COMPLETE: stage = 2'b10;
      S_DONE:     stage = 2'b11;
      default:    stage = 2'b00;
    endcase
  end

  assign seen  = seen_q;
  assign busy  = (state_q == S_ARMED) || (state_q == S_COMPLETE);
  assign done  = (state_q == S_COMPLETE);
  assign fault = (state_q == S_FAULT);

endmodule

// File: tb/tb_fsm_multi_cond_ctrl.sv
// Scoreboard bench: the driver pushes the hand-computed post-edge expectation
// for every cycle it drives; a monitor pops one entry per clock and compares.
module tb_fsm_multi_cond_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cond = '0;
  logic       start = 1'b0;
  logic       clear = 1'b0;

  logic [3:0] seen0, seen1;
  logic [1:0] stage0, stage1;
  logic       busy0, busy1, done0, done1, fault0, fault1;

  always #5 clk = ~clk;

  // Unordered instance
  fsm_multi_cond_ctrl #(.N_COND(4), .ORDERED(0), .TIMEOUT(8), .TMR_W(8)) u_unord (
    .clk(clk), .reset(reset), .cond(cond), .start(start), .clear(clear),
    .seen(seen0), .stage(stage0), .busy(busy0), .done(done0), .fault(fault0)
  );

  // Ordered instance
  fsm_multi_cond_ctrl #(.N_COND(4), .ORDERED(1), .TIMEOUT(8), .TMR_W(8)) u_ord (
    .clk(clk), .reset(reset), .cond(cond), .start(start), .clear(clear),
    .seen(seen1), .stage(stage1), .busy(busy1), .done(done1), .fault(fault1)
  );

  typedef struct {
    logic       sel;
    logic [3:0] seen;
    logic [1:0] stage;
    logic       fault;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   vid = 0;

  // Drive one cycle of inputs and queue the outputs expected after that edge
  task automatic step(input logic sel, input logic [3:0] c, input logic st,
                      input logic cl, input logic rs,
                      input logic [3:0] e_seen, input logic [1:0] e_stage,
                      input logic e_fault);
    exp_t e;
    @(negedge clk);
    cond  = c;
    start = st;
    clear = cl;
    reset = rs;
    e.sel   = sel;
    e.seen  = e_seen;
    e.stage = e_stage;
    e.fault = e_fault;
    e.id    = vid;
    vid++;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the selected instance against the oldest expectation
  initial begin
    exp_t       e;
    logic [3:0] g_seen;
    logic [1:0] g_stage;
    logic       g_busy, g_done, g_fault, e_busy, e_done;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e       = exp_q.pop_front();
        g_seen  = e.sel ? seen1  : seen0;
        g_stage = e.sel ? stage1 : stage0;
        g_busy  = e.sel ? busy1  : busy0;
        g_done  = e.sel ? done1  : done0;
        g_fault = e.sel ? fault1 : fault0;
        e_busy  = (e.stage == 2'b01) || (e.stage == 2'b10);
        e_done  = (e.stage == 2'b10);
        vectors++;
        if (g_seen !== e.seen || g_stage !== e.stage || g_busy !== e_busy ||
            g_done !== e_done || g_fault !== e.fault) begin
          miscompares++;
          $display("FAIL v%0d dut%0d: got seen=%b stage=%b busy=%b done=%b fault=%b, want seen=%b stage=%b busy=%b done=%b fault=%b",
                   e.id, e.sel, g_seen, g_stage, g_busy, g_done, g_fault,
                   e.seen, e.stage, e_busy, e_done, e.fault);
        end
      end
    end
  end

  initial begin
    int budget;
    // Reset state on both instances
    step(0, 4'b0000, 0, 0, 1, 4'b0000, 2'b00, 0);
    step(1, 4'b0000, 0, 0, 1, 4'b0000, 2'b00, 0);

    // Start with nothing seen is ignored
    step(0, 4'b0000, 1, 0, 0, 4'b0000, 2'b00, 0);

    // Unordered happy path
    step(0, 4'b0001, 0, 0, 0, 4'b0001, 2'b00, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b0001, 2'b01, 0);
    step(0, 4'b1110, 0, 0, 0, 4'b1111, 2'b01, 0);
    step(0, 4'b0000, 0, 0, 0, 4'b1111, 2'b10, 0);
    step(0, 4'b0000, 0, 0, 0, 4'b1111, 2'b11, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b1111, 2'b11, 0);
    // Reset while in DONE
    step(0, 4'b0000, 0, 0, 1, 4'b0000, 2'b00, 0);

    // Pre-collected: start jumps straight to COMPLETE
    step(0, 4'b1111, 0, 0, 0, 4'b1111, 2'b00, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b1111, 2'b10, 0);
    step(0, 4'b0000, 0, 0, 0, 4'b1111, 2'b11, 0);
    step(0, 4'b0000, 0, 1, 0, 4'b0000, 2'b00, 0);

    // Timeout: 8 observed ARMED cycles then FAULT
    step(0, 4'b0011, 0, 0, 0, 4'b0011, 2'b00, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b0011, 2'b01, 0);
    for (int i = 0; i < 7; i++) step(0, 4'b0000, 0, 0, 0, 4'b0011, 2'b01, 0);
    step(0, 4'b0000, 0, 0, 0, 4'b0011, 2'b00, 1);
    step(0, 4'b1111, 1, 0, 0, 4'b0011, 2'b00, 1);
    step(0, 4'b0000, 0, 1, 0, 4'b0000, 2'b00, 0);

    // Timeout race: all_seen in the final ARMED cycle wins
    step(0, 4'b0011, 0, 0, 0, 4'b0011, 2'b00, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b0011, 2'b01, 0);
    for (int i = 0; i < 6; i++) step(0, 4'b0000, 0, 0, 0, 4'b0011, 2'b01, 0);
    step(0, 4'b1100, 0, 0, 0, 4'b1111, 2'b01, 0);
    step(0, 4'b0000, 0, 0, 0, 4'b1111, 2'b10, 0);
    step(0, 4'b0000, 0, 0, 0, 4'b1111, 2'b11, 0);
    step(0, 4'b0000, 0, 1, 0, 4'b0000, 2'b00, 0);

    // Clear mid-ARMED beats simultaneous cond/start
    step(0, 4'b0111, 0, 0, 0, 4'b0111, 2'b00, 0);
    step(0, 4'b0000, 1, 0, 0, 4'b0111, 2'b01, 0);
    step(0, 4'b1000, 1, 1, 0, 4'b0000, 2'b00, 0);

    // Ordered: wrong bit faults and freezes seen
    step(1, 4'b0000, 0, 0, 1, 4'b0000, 2'b00, 0);
    step(1, 4'b0001, 0, 0, 0, 4'b0001, 2'b00, 0);
    step(1, 4'b0100, 0, 0, 0, 4'b0001, 2'b00, 1);
    step(1, 4'b0000, 1, 0, 0, 4'b0001, 2'b00, 1);
    step(1, 4'b0000, 0, 1, 0, 4'b0000, 2'b00, 0);

    // Ordered: expected bit plus an extra bit is also an error
    step(1, 4'b0011, 0, 0, 0, 4'b0000, 2'b00, 1);
    step(1, 4'b0000, 0, 1, 0, 4'b0000, 2'b00, 0);

    // Ordered happy path with held levels
    step(1, 4'b0001, 0, 0, 0, 4'b0001, 2'b00, 0);
    step(1, 4'b0001, 0, 0, 0, 4'b0001, 2'b00, 0);
    step(1, 4'b0011, 1, 0, 0, 4'b0011, 2'b01, 0);
    step(1, 4'b0111, 0, 0, 0, 4'b0111, 2'b01, 0);
    step(1, 4'b1111, 0, 0, 0, 4'b1111, 2'b01, 0);
    step(1, 4'b1111, 0, 0, 0, 4'b1111, 2'b10, 0);
    step(1, 4'b0000, 0, 0, 0, 4'b1111, 2'b11, 0);

    // Ordered: out-of-order bit while ARMED faults
    step(1, 4'b0000, 0, 1, 0, 4'b0000, 2'b00, 0);
    step(1, 4'b0001, 1, 0, 0, 4'b0001, 2'b00, 0);
    step(1, 4'b0000, 1, 0, 0, 4'b0001, 2'b01, 0);
    step(1, 4'b1000, 0, 0, 0, 4'b0001, 2'b00, 1);

    // Drain the scoreboard within a bounded number of cycles
    @(negedge clk);
    cond  = '0;
    start = 1'b0;
    clear = 1'b0;
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fsm_multi_cond_ctrl.md
Name: fsm_multi_cond_ctrl

Overview:
- Parametrised condition-gathering controller with two cooperating parts.
- A tracker (Moore) accumulates N_COND condition inputs into a "seen" mask, either in any order or in strict index order.
- A controller, armed by start, walks IDLE -> ARMED -> COMPLETE -> DONE and reports a 2-bit stage code plus busy.
- Adds what the 2-condition predecessor lacked: N conditions, ordered mode, ARMED timeout with fault, explicit clear.

Parameters:
N_COND, 4, number of condition inputs (2..8).
ORDERED, 0, 0 = any arrival order accepted; 1 = conditions must arrive in index order 0,1,2,...
TIMEOUT, 16, maximum cycles spent in ARMED before fault (>=2).
TMR_W, 8, timer width; must satisfy TIMEOUT < 2**TMR_W.

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-high; clears all state
cond  in  N_COND  condition inputs, sampled every cycle (level or pulse)
start  in  1  arm request
clear  in  1  synchronous abort/restart to IDLE
seen  out  N_COND  registered mask of accepted conditions
stage  out  2  00 IDLE/FAULT, 01 ARMED, 10 COMPLETE, 11 DONE
busy  out  1  high in ARMED and COMPLETE
done  out  1  one-cycle pulse, high while in COMPLETE
fault  out  1  high while in FAULT

Behaviour:
- Reset (sync, highest priority) sets: state=IDLE, seen=0, ptr=0, timer=0. All outputs are 0 the cycle after reset is sampled.
- clear (next priority) has the same effect as reset from any state.
- All outputs are registered or decoded from registered state. all_seen = &seen, taken from the registered mask.
- Tracker updates only in IDLE and ARMED; seen is frozen in COMPLETE, DONE and FAULT.
- Define new = cond & ~seen. Bits already seen are ignored.
- ORDERED=0: seen <= seen | cond. A cond bit is visible in seen one cycle after it is sampled.
- ORDERED=1:
  - If new == (1<<ptr): set that bit and increment ptr.
  - If new == 0: no change.
  - Otherwise (wrong bit, or extra bits alongside the expected one): order error.
- Order error in IDLE or ARMED goes to FAULT next cycle; seen is not updated on that cycle.
- Controller state is 3-bit internal, with states IDLE, ARMED, COMPLETE, DONE, FAULT.
- IDLE:
  - start && all_seen -> COMPLETE (skips ARMED).
  - start && seen!=0 -> ARMED.
  - start with seen==0 -> stay in IDLE (request ignored).
- ARMED:
  - timer is 0 on entry and increments every ARMED cycle.
  - all_seen -> COMPLETE.
  - else timer==TIMEOUT-1 -> FAULT.
  - ARMED therefore lasts at most TIMEOUT cycles.
  - all_seen and timer expiry in the same cycle -> COMPLETE wins.
  - start while in ARMED is ignored.
- COMPLETE: unconditionally -> DONE after one cycle; done=1 for exactly that cycle.
- DONE: hold (stage=11) until clear or reset; cond and start are ignored.
- FAULT: hold (stage=00, fault=1) until clear or reset.
- Priority within a cycle: reset > clear > order error > all_seen > timeout > start.
- The timer never wraps: it saturates via the FAULT transition and is cleared on leaving ARMED.

Test Plan:
1. Unordered happy path (N_COND=4, ORDERED=0): reset; cond=0001 -> seen=0001; start -> stage=01, busy=1; cond=1110 one cycle -> seen=1111. Next cycle stage=10, done=1; following cycle stage=11, done=0, busy=0.
2. Pre-collected skip: cond=1111 while in IDLE, then start -> stage goes 00 -> 10 directly; done pulses once; then DONE.
3. Ordered violation (ORDERED=1): cond=0001 then cond=0100 -> fault=1, stage=00, seen stays 0001. clear -> fault=0, seen=0000.
4. Timeout (TIMEOUT=8): seen=0011, start, then no further cond -> after exactly 8 ARMED cycles fault=1. Variant: last bit arrives so all_seen is true in cycle 8 -> COMPLETE, no fault.
5. Clear and reset mid-operation: in ARMED with seen=0111, assert clear -> next cycle stage=00, busy=0, seen=0; reset in DONE -> all outputs 0.
6. Ordered happy path with hold levels: cond held at 0001, then 0011, then 0111, then 1111 (ORDERED=1) -> no fault, ptr advances once per cycle, seen reaches 1111 -> COMPLETE.
